// File: rtl/floo_pkg.sv
// rtl/floo_pkg.sv - shared flit typedefs and AXI response codes for the ring-on-mesh NoC
package floo_pkg;

  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespExOkay = 2'd1;
  localparam logic [1:0] RespSlvErr = 2'd2;
  localparam logic [1:0] RespDecErr = 2'd3;

  localparam int unsigned McastTxnIdWidth = 2;

  typedef struct packed {
    logic                       ring_on_mesh_mcast;
    logic [McastTxnIdWidth-1:0] mcast_txn_id;
    logic [3:0]                 src_id;
    logic [3:0]                 dst_id;
  } floo_hdr_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [7:0] data;
  } floo_payload_t;

  typedef struct packed {
    floo_hdr_t     hdr;
    floo_payload_t payload;
  } floo_flit_t;

  // AXI codes are ordered by severity, so the worst response is the numeric max
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/floo_mcast_txn_table.sv
// rtl/floo_mcast_txn_table.sv - per-transaction response count and sticky merged response
module floo_mcast_txn_table
  import floo_pkg::*;
#(
  parameter int unsigned NumNodes  = 16,
  parameter int unsigned NumTxnIds = 4,
  parameter int unsigned IdW       = (NumTxnIds > 1) ? $clog2(NumTxnIds) : 1,
  parameter int unsigned CntW      = (NumNodes > 2) ? $clog2(NumNodes) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IdW-1:0]       lookup_id_i,
  output logic [CntW-1:0]      cnt_o,
  output logic [1:0]           resp_o,
  input  logic                 upd_i,
  input  logic [1:0]           upd_resp_i,
  input  logic                 clr_i,
  output logic [NumTxnIds-1:0] pending_o
);

  logic [CntW-1:0] cnt_q  [NumTxnIds];
  logic [1:0]      resp_q [NumTxnIds];

  assign cnt_o  = cnt_q[lookup_id_i];
  assign resp_o = resp_q[lookup_id_i];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '{default: '0};
      resp_q <= '{default: '0};
    end else if (clr_i) begin
      cnt_q[lookup_id_i]  <= '0;
      resp_q[lookup_id_i] <= RespOkay;
    end else if (upd_i) begin
      cnt_q[lookup_id_i]  <= cnt_q[lookup_id_i] + CntW'(1);
      resp_q[lookup_id_i] <= resp_merge(resp_q[lookup_id_i], upd_resp_i);
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < NumTxnIds; i++) begin
      pending_o[i] = (cnt_q[i] != '0);
    end
  end

endmodule

// File: rtl/floo_ring_mcast_resp_merger.sv
// rtl/floo_ring_mcast_resp_merger.sv - merges multicast responses into one flit per transaction
module floo_ring_mcast_resp_merger
  import floo_pkg::*;
#(
  parameter int unsigned NumNodes  = 16,
  parameter int unsigned NumTxnIds = 4,
  parameter type         flit_t    = floo_pkg::floo_flit_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  flit_t                data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output flit_t                data_o,
  output logic [NumTxnIds-1:0] pending_o
);

  localparam int unsigned IdW  = (NumTxnIds > 1) ? $clog2(NumTxnIds) : 1;
  localparam int unsigned CntW = (NumNodes > 2) ? $clog2(NumNodes) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumNodes - 2);

  logic            out_valid_q;
  flit_t           out_data_q;
  flit_t           out_next;
  logic [IdW-1:0]  id;
  logic [CntW-1:0] cnt;
  logic [1:0]      resp;
  logic            is_mcast, is_final, out_free;
  logic            load, upd, clr;

  assign id = IdW'(data_i.hdr.mcast_txn_id);

  floo_mcast_txn_table #(
    .NumNodes  (NumNodes),
    .NumTxnIds (NumTxnIds),
    .IdW       (IdW),
    .CntW      (CntW)
  ) i_table (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .lookup_id_i (id),
    .cnt_o       (cnt),
    .resp_o      (resp),
    .upd_i       (upd),
    .upd_resp_i  (data_i.payload.resp),
    .clr_i       (clr),
    .pending_o   (pending_o)
  );

  // Non-final responses are absorbed into the table, so they never wait on the output
  always_comb begin
    is_mcast = data_i.hdr.ring_on_mesh_mcast;
    is_final = is_mcast && (cnt == LastCnt);
    out_free = !out_valid_q || ready_i;
    ready_o  = (is_mcast && !is_final) ? 1'b1 : out_free;
    load     = valid_i && out_free && (!is_mcast || is_final);
    upd      = valid_i && is_mcast && !is_final;
    clr      = valid_i && is_final && out_free;
    out_next = data_i;
    if (is_mcast) begin
      out_next.payload.resp           = resp_merge(resp, data_i.payload.resp);
      out_next.hdr.ring_on_mesh_mcast = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_next;
    end else if (ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;

endmodule
